// File: rtl/demux_rr_lanes.sv
// demux_rr_lanes: 1-to-LANES round-robin deserializer (slot or packed mode).
// Ports: clk_4f, reset (async high), data_in/valid_in/flush in; data_out/valid_out/frame_out/frame_cnt out.
module demux_rr_lanes #(
  parameter int WIDTH  = 8,
  parameter int LANES  = 2,
  parameter int PACKED = 0
) (
  input  logic                   clk_4f,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   valid_in,
  input  logic                   flush,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [LANES-1:0]       valid_out,
  output logic                   frame_out,
  output logic [15:0]            frame_cnt
);

  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [PW-1:0] LAST = PW'(LANES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state;
  state_t state_nxt;

  logic [PW-1:0]    ptr;
  logic [WIDTH-1:0] stg_data [LANES];
  logic [LANES-1:0] stg_valid;

  logic wr;
  logic done;
  logic fl_emit;
  logic emit;
  logic [LANES*WIDTH-1:0] mrg_data;
  logic [LANES-1:0]       mrg_valid;

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // flush dominates completion: a flushed group always restarts in IDLE
  always_comb begin
    state_nxt = state;
    priority case (1'b1)
      fl_emit: state_nxt = IDLE;
      done: begin
        if (PACKED == 0 && mrg_valid == '0) state_nxt = IDLE;
        else                                state_nxt = RUN;
      end
      wr:      state_nxt = RUN;
      default: state_nxt = state;
    endcase
  end

  // staging above ptr is always clear, so unfilled lanes merge as zero
  always_comb begin
    if (state == IDLE)    wr = valid_in;
    else if (PACKED != 0) wr = valid_in;
    else                  wr = 1'b1;
    done    = wr && (ptr == LAST);
    fl_emit = flush && (wr || ptr != '0);
    emit    = done || fl_emit;
    mrg_data  = '0;
    mrg_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      mrg_data[i*WIDTH +: WIDTH] = stg_data[i];
      mrg_valid[i]               = stg_valid[i];
      if (wr && ptr == PW'(i)) begin
        mrg_data[i*WIDTH +: WIDTH] = data_in;
        mrg_valid[i]               = valid_in;
      end
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      stg_valid <= '0;
      for (int i = 0; i < LANES; i++) stg_data[i] <= '0;
      data_out  <= '0;
      valid_out <= '0;
      frame_out <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      frame_out <= emit;
      if (emit) begin
        ptr       <= '0;
        stg_valid <= '0;
        for (int i = 0; i < LANES; i++) stg_data[i] <= '0;
        data_out  <= mrg_data;
        valid_out <= mrg_valid;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (wr) begin
        stg_data[ptr]  <= data_in;
        stg_valid[ptr] <= valid_in;
        ptr            <= ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_rr_lanes.sv
// tb_demux_rr_lanes: four parameter sets driven in parallel,
// checked every cycle against a word-list reference model.
module tb_demux_rr_lanes;

  logic       clk_4f = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] data_in  = '0;
  logic       valid_in = 1'b0;
  logic       flush    = 1'b0;

  logic [15:0] d0; logic [1:0] v0; logic fo0; logic [15:0] c0;
  logic [31:0] d1; logic [3:0] v1; logic fo1; logic [15:0] c1;
  logic [23:0] d2; logic [2:0] v2; logic fo2; logic [15:0] c2;
  logic [24:0] d3; logic [4:0] v3; logic fo3; logic [15:0] c3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_4f = ~clk_4f;

  demux_rr_lanes #(.WIDTH(8), .LANES(2), .PACKED(0)) u0 (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in),
    .valid_in(valid_in), .flush(flush), .data_out(d0),
    .valid_out(v0), .frame_out(fo0), .frame_cnt(c0));
  demux_rr_lanes #(.WIDTH(8), .LANES(4), .PACKED(1)) u1 (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in),
    .valid_in(valid_in), .flush(flush), .data_out(d1),
    .valid_out(v1), .frame_out(fo1), .frame_cnt(c1));
  demux_rr_lanes #(.WIDTH(8), .LANES(3), .PACKED(0)) u2 (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in),
    .valid_in(valid_in), .flush(flush), .data_out(d2),
    .valid_out(v2), .frame_out(fo2), .frame_cnt(c2));
  demux_rr_lanes #(.WIDTH(5), .LANES(5), .PACKED(1)) u3 (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in[4:0]),
    .valid_in(valid_in), .flush(flush), .data_out(d3),
    .valid_out(v3), .frame_out(fo3), .frame_cnt(c3));

  int L[4] = '{2, 4, 3, 5};
  int P[4] = '{0, 1, 0, 1};
  int W[4] = '{8, 8, 8, 5};

  logic [63:0] pd [4][16];
  bit          pv [4][16];
  int          pn [4];
  bit          act[4];
  logic [63:0] m_data [4];
  logic [15:0] m_valid[4];
  logic        m_fo   [4];
  logic [15:0] m_cnt  [4];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      pn[k] = 0; act[k] = 0;
      m_data[k] = '0; m_valid[k] = '0;
      m_fo[k] = 1'b0; m_cnt[k] = '0;
    end
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d,
                            input bit f);
    for (int k = 0; k < 4; k++) begin
      logic [63:0] wd;
      bit wr, anyv;
      wd = 64'(d) & ((64'd1 << W[k]) - 64'd1);
      wr = act[k] ? (P[k] != 0 ? v : 1'b1) : v;
      if (wr) begin
        pd[k][pn[k]] = wd; pv[k][pn[k]] = v; pn[k]++;
      end
      if (pn[k] == L[k] || (f && pn[k] > 0)) begin
        m_data[k] = '0; m_valid[k] = '0; anyv = 0;
        for (int i = 0; i < pn[k]; i++) begin
          m_data[k]  |= pd[k][i] << (i * W[k]);
          m_valid[k] |= 16'(pv[k][i]) << i;
          anyv |= pv[k][i];
        end
        m_fo[k] = 1'b1;
        m_cnt[k]++;
        act[k] = f ? 0 : (P[k] != 0 ? 1 : anyv);
        pn[k] = 0;
      end else begin
        m_fo[k] = 1'b0;
        if (wr) act[k] = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("u0.data",  64'(d0),  m_data[0]);
    chk("u0.valid", 64'(v0),  64'(m_valid[0]));
    chk("u0.frame", 64'(fo0), 64'(m_fo[0]));
    chk("u0.cnt",   64'(c0),  64'(m_cnt[0]));
    chk("u1.data",  64'(d1),  m_data[1]);
    chk("u1.valid", 64'(v1),  64'(m_valid[1]));
    chk("u1.frame", 64'(fo1), 64'(m_fo[1]));
    chk("u1.cnt",   64'(c1),  64'(m_cnt[1]));
    chk("u2.data",  64'(d2),  m_data[2]);
    chk("u2.valid", 64'(v2),  64'(m_valid[2]));
    chk("u2.frame", 64'(fo2), 64'(m_fo[2]));
    chk("u2.cnt",   64'(c2),  64'(m_cnt[2]));
    chk("u3.data",  64'(d3),  m_data[3]);
    chk("u3.valid", 64'(v3),  64'(m_valid[3]));
    chk("u3.frame", 64'(fo3), 64'(m_fo[3]));
    chk("u3.cnt",   64'(c3),  64'(m_cnt[3]));
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit f);
    valid_in = v; data_in = d; flush = f;
    @(posedge clk_4f);
    @(negedge clk_4f);
    if (reset) model_reset();
    else       model_edge(v, d, f);
    check_all();
  endtask

  // asserts reset between edges, checks the immediate clear,
  // holds it over one edge and leaves it asserted
  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    step(0, 8'h00, 0);
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    chk("rst.data", 64'(d1), 64'h0);
    chk("rst.cnt",  64'(c0), 64'h0);
    step(0, 8'h00, 0);

    reset = 1'b0;
    step(1, 8'hff, 0);
    step(1, 8'hdd, 0);
    chk("t1.data1",  64'(d0),  64'hddff);
    chk("t1.valid1", 64'(v0),  64'h3);
    chk("t1.frame1", 64'(fo0), 64'h1);
    step(1, 8'hee, 0);
    chk("t1.fdrop",  64'(fo0), 64'h0);
    step(1, 8'hcc, 0);
    chk("t1.data2",  64'(d0),  64'hccee);
    chk("t1.cnt",    64'(c0),  64'd2);

    async_reset(); reset = 1'b0;
    step(1, 8'h88, 0);
    step(0, 8'h55, 0);
    chk("t2.data",   64'(d0), 64'h5588);
    chk("t2.valid",  64'(v0), 64'h1);
    step(1, 8'h77, 0);
    step(1, 8'h66, 0);
    chk("t2.next",   64'(d0), 64'h6677);

    async_reset(); reset = 1'b0;
    step(1, 8'haa, 0);
    step(0, 8'h01, 0);
    chk("t3.idlefo", 64'(fo1), 64'h0);
    step(1, 8'hbb, 0);
    step(0, 8'h02, 0);
    step(0, 8'h03, 0);
    step(1, 8'hcc, 0);
    chk("t3.nofr",   64'(fo1), 64'h0);
    step(1, 8'hdd, 0);
    chk("t3.data",   64'(d1), 64'hddccbbaa);
    chk("t3.valid",  64'(v1), 64'hf);
    chk("t3.cnt",    64'(c1), 64'd1);

    async_reset(); reset = 1'b0;
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(0, 8'h99, 1);
    chk("t4.data",   64'(d1), 64'h00002211);
    chk("t4.valid",  64'(v1), 64'h3);
    step(0, 8'h98, 1);
    chk("t4.nofl",   64'(fo1), 64'h0);
    step(1, 8'h33, 0);
    step(0, 8'h00, 1);
    chk("t4.lane0",  64'(d1), 64'h00000033);

    async_reset(); reset = 1'b0;
    for (int i = 1; i <= 7; i++) step(1, 8'(i), 0);
    async_reset();
    chk("t5.clr",    64'(d1), 64'h0);
    reset = 1'b0;
    for (int i = 8; i <= 11; i++) step(1, 8'(i), 0);
    chk("t5.data",   64'(d1), 64'h0b0a0908);
    chk("t5.cnt",    64'(c1), 64'd1);

    async_reset(); reset = 1'b0;
    for (int i = 0; i < 65540; i++) step(1, 8'(i), 1);
    chk("t6.wrap",   64'(c2), 64'd4);
    for (int g = 0; g < 2; g++) begin
      step(1, 8'(8'h10 + 3*g), 0);
      step(1, 8'(8'h11 + 3*g), 0);
      step(1, 8'(8'h12 + 3*g), 0);
      chk("t6.order", 64'(d2),
          64'(24'h121110 + 24'h030303 * g));
    end

    async_reset(); reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset(); reset = 1'b0;
      end
      step($urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
